// File: rtl/pipe_flow_ctrl.sv
// Session controller for the host pipe path: sequences N blocks through in-FIFO, pattern engine, out-FIFO.
// Latency: ready/stream/status flags are registered, reflecting FIFO counts sampled one cycle earlier.
// Backpressure: ready flags deassert on insufficient FIFO room/data or target reached; watchdog via PIPE_FLOW_TIMEOUT_EN.
module pipe_flow_ctrl #(
    parameter int unsigned IN_DEPTH       = 1024,
    parameter int unsigned BLOCK_WORDS    = 128,
    parameter int unsigned CNT_W          = 10,
    parameter int unsigned BLK_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic [CNT_W-1:0] in_wr_count,
    input  logic [CNT_W-1:0] out_rd_count,
    input  logic             pi_write,
    input  logic             po_read,
    output logic             pipe_in_ready,
    output logic             pipe_out_ready,
    output logic             stream_en,
    output logic             busy,
    output logic             done,
    output logic [BLK_W-1:0] blocks_in,
    output logic [BLK_W-1:0] blocks_out,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             err_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned         WORD_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [WORD_W-1:0]   WORD_LAST = WORD_W'(BLOCK_WORDS - 1);
    localparam logic [31:0]         IN_HIGH   = 32'(IN_DEPTH - BLOCK_WORDS);

    logic [1:0]        state_q, state_nx;
    logic [BLK_W-1:0]  target_q, target_nx;
    logic [WORD_W-1:0] in_word_q, in_word_nx;
    logic [WORD_W-1:0] out_word_q, out_word_nx;
    logic [BLK_W-1:0]  bin_nx, bout_nx;
    logic              ovf_nx, unf_nx;
    logic              start_acc;
    logic              wd_fire;
    logic [31:0]       in_cnt_ext, out_cnt_ext;

    assign in_cnt_ext  = 32'(in_wr_count);
    assign out_cnt_ext = 32'(out_rd_count);
    assign start_acc   = (state_q == ST_IDLE) && start && (num_blocks != '0);

    // Next-state, word/block counting and error detection for the session
    always_comb begin
        state_nx    = state_q;
        target_nx   = target_q;
        in_word_nx  = in_word_q;
        out_word_nx = out_word_q;
        bin_nx      = blocks_in;
        bout_nx     = blocks_out;
        ovf_nx      = err_overflow;
        unf_nx      = err_underflow;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_nx    = ST_RUN;
                    target_nx   = num_blocks;
                    in_word_nx  = '0;
                    out_word_nx = '0;
                    bin_nx      = '0;
                    bout_nx     = '0;
                    ovf_nx      = 1'b0;
                    unf_nx      = 1'b0;
                end
            end
            ST_RUN: begin
                // A write beyond the session target or into a full FIFO is flagged and dropped
                if (pi_write) begin
                    if ((blocks_in == target_q) || (in_cnt_ext == IN_DEPTH)) begin
                        ovf_nx = 1'b1;
                    end else if (in_word_q == WORD_LAST) begin
                        in_word_nx = '0;
                        bin_nx     = blocks_in + BLK_W'(1);
                    end else begin
                        in_word_nx = in_word_q + WORD_W'(1);
                    end
                end
                // An underflowing read is flagged but still counted; counting stops at target
                if (po_read) begin
                    if (out_rd_count == '0) begin
                        unf_nx = 1'b1;
                    end
                    if (blocks_out != target_q) begin
                        if (out_word_q == WORD_LAST) begin
                            out_word_nx = '0;
                            bout_nx     = blocks_out + BLK_W'(1);
                        end else begin
                            out_word_nx = out_word_q + WORD_W'(1);
                        end
                    end
                end
                if ((blocks_out == target_q) || wd_fire) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Session state, counters and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            in_word_q      <= '0;
            out_word_q     <= '0;
            blocks_in      <= '0;
            blocks_out     <= '0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            stream_en      <= 1'b0;
            pipe_in_ready  <= 1'b0;
            pipe_out_ready <= 1'b0;
        end else begin
            state_q        <= state_nx;
            target_q       <= target_nx;
            in_word_q      <= in_word_nx;
            out_word_q     <= out_word_nx;
            blocks_in      <= bin_nx;
            blocks_out     <= bout_nx;
            err_overflow   <= ovf_nx;
            err_underflow  <= unf_nx;
            busy           <= (state_nx != ST_IDLE);
            done           <= (state_nx == ST_DONE);
            // Engine starts once a full block is buffered and stops as RUN is left
            stream_en      <= (state_q == ST_RUN) && (state_nx == ST_RUN) && (blocks_in != '0);
            // Looking at next-cycle counts lets ready drop no later than the block that hits target
            pipe_in_ready  <= (state_nx == ST_RUN) && (in_cnt_ext <= IN_HIGH) && (bin_nx < target_nx);
            pipe_out_ready <= (state_nx == ST_RUN) && (out_cnt_ext >= BLOCK_WORDS) && (bout_nx < target_nx);
        end
    end

`ifdef PIPE_FLOW_TIMEOUT_EN
    localparam int unsigned       WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_nx;

    // Idle watchdog: counts consecutive strobe-free RUN cycles
    always_comb begin
        wd_nx   = '0;
        wd_fire = 1'b0;
        if ((state_q == ST_RUN) && !(pi_write || po_read)) begin
            if (wd_q == WD_LAST) begin
                wd_fire = 1'b1;
            end else begin
                wd_nx = wd_q + WD_W'(1);
            end
        end
    end

    // Watchdog count and sticky timeout flag, cleared on the next accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q        <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd_q <= wd_nx;
            if (start_acc) begin
                err_timeout <= 1'b0;
            end else if (wd_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_fire            = 1'b0;
    assign err_timeout        = 1'b0;
    assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed session scenarios plus randomized sessions.
// Every cycle all outputs are compared against a word-total based reference model.
// Strobes are driven freely; the model decides which ones the controller should honour.
module tb_pipe_flow_ctrl;

    localparam int IN_DEPTH = 1024;
    localparam int BW       = 128;
    localparam int CNT_W    = 10;
    localparam int BLK_W    = 16;
    localparam int TO       = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [BLK_W-1:0] num_blocks;
    logic [CNT_W-1:0] in_wr_count;
    logic [CNT_W-1:0] out_rd_count;
    logic             pi_write;
    logic             po_read;
    logic             pipe_in_ready;
    logic             pipe_out_ready;
    logic             stream_en;
    logic             busy;
    logic             done;
    logic [BLK_W-1:0] blocks_in;
    logic [BLK_W-1:0] blocks_out;
    logic             err_overflow;
    logic             err_underflow;
    logic             err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    // Reference model: session phase (0 idle, 1 run, 2 done) and total words moved
    int m_phase, m_target, m_in_words, m_out_words, m_idle;
    bit m_ovf, m_unf, m_to, m_sen, m_pir, m_por;

    pipe_flow_ctrl #(
        .IN_DEPTH       (IN_DEPTH),
        .BLOCK_WORDS    (BW),
        .CNT_W          (CNT_W),
        .BLK_W          (BLK_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_blocks     (num_blocks),
        .in_wr_count    (in_wr_count),
        .out_rd_count   (out_rd_count),
        .pi_write       (pi_write),
        .po_read        (po_read),
        .pipe_in_ready  (pipe_in_ready),
        .pipe_out_ready (pipe_out_ready),
        .stream_en      (stream_en),
        .busy           (busy),
        .done           (done),
        .blocks_in      (blocks_in),
        .blocks_out     (blocks_out),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int ph_old, bin_old, bout_old;
        ph_old   = m_phase;
        bin_old  = m_in_words / BW;
        bout_old = m_out_words / BW;
        if (reset) begin
            m_phase = 0; m_target = 0; m_in_words = 0; m_out_words = 0; m_idle = 0;
            m_ovf = 0; m_unf = 0; m_to = 0; m_sen = 0; m_pir = 0; m_por = 0;
            return;
        end
        case (ph_old)
            0: begin
                if (start && num_blocks != 0) begin
                    m_phase = 1; m_target = int'(num_blocks);
                    m_in_words = 0; m_out_words = 0;
                    m_ovf = 0; m_unf = 0; m_to = 0;
                end
            end
            1: begin
                if (pi_write) begin
                    if (bin_old == m_target || int'(in_wr_count) == IN_DEPTH) m_ovf = 1;
                    else m_in_words++;
                end
                if (po_read) begin
                    if (out_rd_count == 0) m_unf = 1;
                    if (bout_old < m_target) m_out_words++;
                end
                if (bout_old == m_target) m_phase = 2;
`ifdef PIPE_FLOW_TIMEOUT_EN
                if (pi_write || po_read) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle >= TO) begin m_to = 1; m_phase = 2; end
                end
`endif
            end
            default: m_phase = 0;
        endcase
        if (m_phase != 1) m_idle = 0;
        m_sen = (ph_old == 1) && (m_phase == 1) && (bin_old >= 1);
        m_pir = (m_phase == 1) && (int'(in_wr_count) <= IN_DEPTH - BW) && (m_in_words / BW < m_target);
        m_por = (m_phase == 1) && (int'(out_rd_count) >= BW) && (m_out_words / BW < m_target);
    endtask

    task automatic compare_all();
        check_eq("busy",           busy,           m_phase != 0);
        check_eq("done",           done,           m_phase == 2);
        check_eq("stream_en",      stream_en,      m_sen);
        check_eq("pipe_in_ready",  pipe_in_ready,  m_pir);
        check_eq("pipe_out_ready", pipe_out_ready, m_por);
        check_eq("blocks_in",      blocks_in,      m_in_words / BW);
        check_eq("blocks_out",     blocks_out,     m_out_words / BW);
        check_eq("err_overflow",   err_overflow,   m_ovf);
        check_eq("err_underflow",  err_underflow,  m_unf);
        check_eq("err_timeout",    err_timeout,    m_to);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        if (done) done_seen++;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic writes(input int n);
        pi_write = 1'b1;
        ticks(n);
        pi_write = 1'b0;
    endtask

    task automatic reads(input int n);
        po_read = 1'b1;
        ticks(n);
        po_read = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int in_pick[4];
        int out_pick[4];
        int guard;
        in_pick  = '{0, 896, 897, 1023};
        out_pick = '{0, 127, 128, 300};

        reset = 1'b1; start = 1'b0; num_blocks = '0;
        in_wr_count = '0; out_rd_count = '0; pi_write = 1'b0; po_read = 1'b0;
        m_phase = 0; m_target = 0; m_in_words = 0; m_out_words = 0; m_idle = 0;
        m_ovf = 0; m_unf = 0; m_to = 0; m_sen = 0; m_pir = 0; m_por = 0;
        ticks(3);
        check_eq("reset_busy", busy, 0);
        reset = 1'b0;
        // Strobes in IDLE are ignored without errors
        writes(2);
        reads(2);

        // Directed full 2-block session
        num_blocks = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_pir", pipe_in_ready, 1);
        writes(BW);
        check_eq("first_block_in", blocks_in, 1);
        tick();
        check_eq("stream_en_on", stream_en, 1);
        in_wr_count = 10'd897;
        tick();
        check_eq("pir_897", pipe_in_ready, 0);
        in_wr_count = 10'd896;
        tick();
        check_eq("pir_896", pipe_in_ready, 1);
        writes(BW);
        check_eq("target_in", blocks_in, 2);
        check_eq("pir_target", pipe_in_ready, 0);
        writes(1);
        check_eq("ovf_set", err_overflow, 1);
        check_eq("ovf_hold_blocks", blocks_in, 2);
        reads(1);
        check_eq("unf_set", err_underflow, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_ignored", err_overflow, 1);
        out_rd_count = 10'd128;
        done_seen = 0;
        reads(2 * BW - 1);
        check_eq("target_out", blocks_out, 2);
        ticks(4);
        check_eq("single_done", done_seen, 1);
        check_eq("idle_after", busy, 0);
        check_eq("hold_blocks_in", blocks_in, 2);

        // Idle session: watchdog behaviour, then reset mid-session
        out_rd_count = 10'd0; in_wr_count = 10'd0;
        num_blocks = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        writes(BW);
        done_seen = 0;
        ticks(TO + 50);
`ifdef PIPE_FLOW_TIMEOUT_EN
        check_eq("timeout_flag", err_timeout, 1);
        check_eq("timeout_done", done_seen, 1);
`else
        check_eq("no_timeout_busy", busy, 1);
        check_eq("no_timeout_flag", err_timeout, 0);
`endif
        done_seen = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midreset_busy", busy, 0);
        check_eq("midreset_blocks", blocks_in, 0);
        ticks(2);
        check_eq("midreset_nodone", done_seen, 0);

        // Randomized sessions
        for (int s = 0; s < 8; s++) begin
            num_blocks = '0; start = 1'b1;
            tick();
            start = 1'b0;
            num_blocks = BLK_W'($urandom_range(3, 1));
            in_wr_count  = CNT_W'(in_pick[$urandom_range(3, 0)]);
            out_rd_count = CNT_W'(out_pick[$urandom_range(3, 0)]);
            start = 1'b1;
            tick();
            start = 1'b0;
            guard = 0;
            done_seen = 0;
            while (m_phase != 0 && guard < 3000) begin
                pi_write   = ($urandom_range(9, 0) < 7);
                po_read    = ($urandom_range(9, 0) < 7);
                start      = ($urandom_range(49, 0) == 0);
                num_blocks = BLK_W'($urandom_range(3, 1));
                if ($urandom_range(15, 0) == 0) in_wr_count  = CNT_W'(in_pick[$urandom_range(3, 0)]);
                if ($urandom_range(15, 0) == 0) out_rd_count = CNT_W'(out_pick[$urandom_range(3, 0)]);
                tick();
                guard++;
            end
            start = 1'b0; pi_write = 1'b0; po_read = 1'b0;
            tick();
            check_eq("rand_session_idle", busy, 0);
            check_eq("rand_session_done", done_seen, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
